// File: rtl/rise_event_arbiter_pkg.sv
// Shared definitions for the rise-event arbiter: FSM encodings and the
// channel-index width helper.
package rise_event_arbiter_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } arb_state_e;

   // Channel index width, never narrower than one bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rise_event_arbiter_if.sv
// Event record port: one record per valid/ready handshake.
interface rise_event_arbiter_if
   import rise_event_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
);
   localparam int CH_W = ch_w(DATA_WIDTH);

   logic                 valid;
   logic                 ready;
   logic [CH_W-1:0]      chan;
   logic [CNT_WIDTH-1:0] count;
   logic                 overflow;

   modport master (output valid, chan, count, overflow, input ready);
   modport slave  (input valid, chan, count, overflow, output ready);
endinterface

// File: rtl/rise_event_arbiter_lsb_priority_enc.sv
// Lowest-set-bit encoder: idx is the lowest asserted request, any is its OR.
module lsb_priority_enc
   import rise_event_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   localparam int CH_W      = ch_w(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] req,
   output logic [CH_W-1:0]       idx,
   output logic                  any
);

   always_comb begin
      idx = '0;
      any = |req;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (req[i]) idx = CH_W'(i);
      end
   end

endmodule

// File: rtl/rise_event_arbiter.sv
// Sticky per-channel pending/count/overflow tracking for rise pulses, drained
// lowest-index-first one record at a time over a valid/ready port.
module rise_event_arbiter
   import rise_event_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] pulse_in,
   rise_event_arbiter_if.master  evt,
   output logic [DATA_WIDTH-1:0] pending,
   output logic                  irq
);

   localparam int CH_W = ch_w(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   arb_state_e state, state_next;
   logic [CH_W-1:0]                     chan_q;
   logic [DATA_WIDTH-1:0][CNT_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0]               ovf;
   logic [CH_W-1:0]                     sel_idx;
   logic                                sel_any;
   logic                                take;

   lsb_priority_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
      .req (pending),
      .idx (sel_idx),
      .any (sel_any)
   );

   assign take = evt.valid && evt.ready;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chan
      logic clr;
      assign clr = take && (chan_q == CH_W'(i));

      // A pulse landing on the cycle its channel is popped restarts the
      // record at one event rather than being dropped.
      always_ff @(posedge clk) begin
         if (reset) begin
            pending[i] <= 1'b0;
            cnt[i]     <= '0;
            ovf[i]     <= 1'b0;
         end else if (pulse_in[i]) begin
            pending[i] <= 1'b1;
            if (clr) begin
               cnt[i] <= CNT_WIDTH'(1);
               ovf[i] <= 1'b0;
            end else if (cnt[i] == CNT_MAX) begin
               ovf[i] <= 1'b1;
            end else begin
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
         end else if (clr) begin
            pending[i] <= 1'b0;
            cnt[i]     <= '0;
            ovf[i]     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (sel_any) state_next = ST_PRESENT;
         ST_PRESENT: if (evt.ready) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                             chan_q <= '0;
      else if (state == ST_IDLE && sel_any)  chan_q <= sel_idx;
   end

   always_comb begin
      evt.valid    = (state == ST_PRESENT);
      evt.chan     = chan_q;
      evt.count    = cnt[chan_q];
      evt.overflow = ovf[chan_q];
      irq          = |pending;
   end

endmodule
